pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 13 +
 rtl/pipe_entry_reg.sv | 65 ++++++
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 tb/tb_pipe_stage_reg.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Constants shared by every F/D/E/M/W stage register instance.
// Keeps the boot PC, the bubble encoding and the exception width in one place.
package pipe_stage_reg_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          EXC_W_DEFAULT    = 5;

    function automatic logic [1:0] entryCount(input logic mainValid, input logic skidValid);
        return {1'b0, mainValid} + {1'b0, skidValid};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry (valid, pc, instr, exc) with load enable and clear.
// Clear wins over load and keeps the PC so a killed slot still shows where it was.
module pipe_entry_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter int              EXC_W    = EXC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [EXC_W-1:0]   exc_i,
    output logic               valid_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [EXC_W-1:0]   exc_o
);

    logic               valid_q, valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [EXC_W-1:0]   exc_q, exc_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        if (clear_i) begin
            valid_d = 1'b0;
            instr_d = INSTR_W'(NOP_INSTR);
            exc_d   = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
            exc_d   = exc_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= INSTR_W'(NOP_INSTR);
            exc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign exc_o   = exc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional skid entry so in_ready never depends on out_ready.
// Stall only gates acceptance; flush empties the stage but leaves the last PC visible.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter int              EXC_W    = EXC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
    parameter int              SKID     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [EXC_W-1:0]   in_exc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [EXC_W-1:0]   out_exc,
    output logic [1:0]         occupancy
);

    logic               accept, emit, mainOpen, mainLoad, mainClear;
    logic               mainValid, skidValid;
    logic [PC_W-1:0]    mainPc, skidPc, loadPc;
    logic [INSTR_W-1:0] mainInstr, skidInstr, loadInstr;
    logic [EXC_W-1:0]   mainExc, skidExc, loadExc;

    assign accept    = in_valid & in_ready;
    assign emit      = mainValid & out_ready;
    assign mainOpen  = !mainValid | emit;
    assign mainLoad  = !flush & mainOpen & (skidValid | accept);
    assign mainClear = flush | (mainOpen & !skidValid & !accept);

    // A waiting skid entry is older than anything arriving now, so it takes the main slot first.
    assign loadPc    = skidValid ? skidPc    : in_pc;
    assign loadInstr = skidValid ? skidInstr : in_instr;
    assign loadExc   = skidValid ? skidExc   : in_exc;

    pipe_entry_reg #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .EXC_W    (EXC_W),
        .RESET_PC (RESET_PC)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (mainLoad),
        .clear_i (mainClear),
        .pc_i    (loadPc),
        .instr_i (loadInstr),
        .exc_i   (loadExc),
        .valid_o (mainValid),
        .pc_o    (mainPc),
        .instr_o (mainInstr),
        .exc_o   (mainExc)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic skidLoad, skidClear;

            assign in_ready  = !skidValid & !stall;
            assign skidLoad  = !flush & mainValid & !emit & accept;
            assign skidClear = flush | (emit & skidValid);

            pipe_entry_reg #(
                .PC_W     (PC_W),
                .INSTR_W  (INSTR_W),
                .EXC_W    (EXC_W),
                .RESET_PC (RESET_PC)
            ) u_skid (
                .clk     (clk),
                .reset   (reset),
                .load_i  (skidLoad),
                .clear_i (skidClear),
                .pc_i    (in_pc),
                .instr_i (in_instr),
                .exc_i   (in_exc),
                .valid_o (skidValid),
                .pc_o    (skidPc),
                .instr_o (skidInstr),
                .exc_o   (skidExc)
            );
        end else begin : g_noskid
            assign in_ready  = (!mainValid | out_ready) & !stall;
            assign skidValid = 1'b0;
            assign skidPc    = '0;
            assign skidInstr = '0;
            assign skidExc   = '0;
        end
    endgenerate

    assign out_valid = mainValid;
    assign out_pc    = mainPc;
    assign out_instr = mainValid ? mainInstr : INSTR_W'(NOP_INSTR);
    assign out_exc   = mainExc;
    assign occupancy = entryCount(mainValid, skidValid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid and one single-entry instance share stimulus,
// each compared every cycle with a bounded-FIFO reference model.
module tb_pipe_stage_reg;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } entry_t;

    typedef struct {
        logic        inValid;
        logic [31:0] pc;
        logic        outReady;
        logic        expValid;
        logic [31:0] expPc;
        logic [1:0]  expOcc;
        logic        expReady;
    } vector_t;

    logic        clk = 1'b0;
    logic        reset, stall, flush, inValid, outReady;
    logic [31:0] inPc, inInstr;
    logic [4:0]  inExc;

    logic        readyS, validS, readyN, validN;
    logic [31:0] pcS, instrS, pcN, instrN;
    logic [4:0]  excS, excN;
    logic [1:0]  occS, occN;

    int          checks = 0;
    int          errors = 0;
    entry_t      mem[2][2];
    int          cnt[2];
    logic [31:0] mainPc[2];
    bit          excZero[2];
    bit          armed = 1'b0;
    int          dutEmits[2];

    pipe_stage_reg #(.SKID(1)) dutSkid (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(inValid), .in_ready(readyS), .in_pc(inPc), .in_instr(inInstr), .in_exc(inExc),
        .out_valid(validS), .out_ready(outReady), .out_pc(pcS), .out_instr(instrS), .out_exc(excS),
        .occupancy(occS)
    );

    pipe_stage_reg #(.SKID(0)) dutNoSkid (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(inValid), .in_ready(readyN), .in_pc(inPc), .in_instr(inInstr), .in_exc(inExc),
        .out_valid(validN), .out_ready(outReady), .out_pc(pcN), .out_instr(instrN), .out_exc(excN),
        .occupancy(occN)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic getDut(input int k, output logic v, output logic r, output logic [31:0] p,
                          output logic [31:0] i, output logic [4:0] e, output logic [1:0] o);
        if (k == 1) begin
            v = validS; r = readyS; p = pcS; i = instrS; e = excS; o = occS;
        end else begin
            v = validN; r = readyN; p = pcN; i = instrN; e = excN; o = occN;
        end
    endtask

    // Stage as a FIFO of depth 2 (skid) or 1 with pass-through when the consumer drains it.
    function automatic bit modelReady(input int k);
        if (stall) return 1'b0;
        if (k == 1) return cnt[k] < 2;
        return (cnt[k] == 0) || outReady;
    endfunction

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            cnt[k]     = 0;
            mainPc[k]  = 32'h0000_3000;
            excZero[k] = 1'b1;
        end
    endtask

    task automatic modelAdvance(input int k);
        bit acc, em;
        acc = inValid && modelReady(k);
        em  = (cnt[k] != 0) && outReady;
        if (flush) begin
            cnt[k]     = 0;
            excZero[k] = 1'b1;
        end else begin
            if (em) begin
                mem[k][0] = mem[k][1];
                cnt[k]--;
            end
            if (acc) begin
                mem[k][cnt[k]] = '{pc: inPc, instr: inInstr, exc: inExc};
                cnt[k]++;
            end
            if (cnt[k] != 0) begin
                mainPc[k]  = mem[k][0].pc;
                excZero[k] = 1'b0;
            end
        end
    endtask

    task automatic modelCheck(input int k);
        logic v, r;
        logic [31:0] p, i;
        logic [4:0] e;
        logic [1:0] o;
        string tag;
        getDut(k, v, r, p, i, e, o);
        tag = (k == 1) ? "skid" : "noskid";
        checkOutput({tag, ".out_valid"}, 64'(v), 64'(cnt[k] != 0));
        checkOutput({tag, ".occupancy"}, 64'(o), 64'(cnt[k]));
        checkOutput({tag, ".in_ready"}, 64'(r), 64'(modelReady(k)));
        checkOutput({tag, ".out_pc"}, 64'(p), 64'((cnt[k] != 0) ? mem[k][0].pc : mainPc[k]));
        checkOutput({tag, ".out_instr"}, 64'(i), 64'((cnt[k] != 0) ? mem[k][0].instr : 32'h0));
        if (cnt[k] != 0) checkOutput({tag, ".out_exc"}, 64'(e), 64'(mem[k][0].exc));
        else if (excZero[k]) checkOutput({tag, ".out_exc"}, 64'(e), 64'(0));
    endtask

    // Drive one cycle at the falling edge and check both instances before the next rising edge.
    task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [4:0] exc, input logic ordy, input logic stl, input logic fl);
        @(negedge clk);
        if (armed) begin
            modelAdvance(1);
            modelAdvance(0);
        end
        inValid = iv; inPc = pc; inInstr = instr; inExc = exc;
        outReady = ordy; stall = stl; flush = fl;
        #1;
        modelCheck(1);
        modelCheck(0);
        if (validS && outReady) dutEmits[1]++;
        if (validN && outReady) dutEmits[0]++;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        inValid = 1'b0; outReady = 1'b0; stall = 1'b0; flush = 1'b0;
        reset = 1'b1;
        armed = 1'b1;
    endtask

    function automatic logic [31:0] tagInstr(input logic [31:0] pc);
        return {pc[15:0], 16'hC0DE};
    endfunction

    initial begin
        vector_t vec[7];
        int      seen[2];
        logic [31:0] base;

        vec[0] = '{1'b1, 32'h3000, 1'b0, 1'b0, 32'h3000, 2'd0, 1'b1};
        vec[1] = '{1'b1, 32'h3004, 1'b0, 1'b1, 32'h3000, 2'd1, 1'b1};
        vec[2] = '{1'b1, 32'h3008, 1'b0, 1'b1, 32'h3000, 2'd2, 1'b0};
        vec[3] = '{1'b1, 32'h3008, 1'b1, 1'b1, 32'h3000, 2'd2, 1'b0};
        vec[4] = '{1'b1, 32'h3008, 1'b1, 1'b1, 32'h3004, 2'd1, 1'b1};
        vec[5] = '{1'b0, 32'h0000, 1'b1, 1'b1, 32'h3008, 2'd1, 1'b1};
        vec[6] = '{1'b0, 32'h0000, 1'b1, 1'b0, 32'h3008, 2'd0, 1'b1};

        reset = 1'b0; stall = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inPc = '0; inInstr = '0; inExc = '0;
        resetModel();
        #12;
        checkOutput("reset.out_valid", 64'(validS), 64'(0));
        checkOutput("reset.out_pc", 64'(pcS), 64'(32'h3000));
        checkOutput("reset.out_instr", 64'(instrS), 64'(0));
        checkOutput("reset.out_exc", 64'(excS), 64'(0));
        checkOutput("reset.occupancy", 64'(occS), 64'(0));
        checkOutput("reset.in_ready", 64'(readyS), 64'(1));
        checkOutput("reset.noskid.out_pc", 64'(pcN), 64'(32'h3000));
        stall = 1'b1;
        #1;
        checkOutput("reset.stall.in_ready", 64'(readyN), 64'(0));
        checkOutput("reset.stall.skid.in_ready", 64'(readyS), 64'(0));
        stall = 1'b0;
        releaseReset();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vec[i].inValid, vec[i].pc, tagInstr(vec[i].pc), vec[i].pc[6:2],
                          vec[i].outReady, 1'b0, 1'b0);
            checkOutput($sformatf("tbl%0d.out_valid", i), 64'(validS), 64'(vec[i].expValid));
            checkOutput($sformatf("tbl%0d.out_pc", i), 64'(pcS), 64'(vec[i].expPc));
            checkOutput($sformatf("tbl%0d.occupancy", i), 64'(occS), 64'(vec[i].expOcc));
            checkOutput($sformatf("tbl%0d.in_ready", i), 64'(readyS), 64'(vec[i].expReady));
        end

        // Stall with one held entry: it still drains, nothing new gets in.
        applyStimulus(1'b1, 32'h4000, tagInstr(32'h4000), 5'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h4004, tagInstr(32'h4004), 5'd4, 1'b1, 1'b1, 1'b0);
        checkOutput("stall.in_ready", 64'(readyS), 64'(0));
        checkOutput("stall.out_pc", 64'(pcS), 64'(32'h4000));
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("stall.drained.out_valid", 64'(validS), 64'(0));
        checkOutput("stall.drained.out_instr", 64'(instrS), 64'(0));
        checkOutput("stall.drained.noskid.out_valid", 64'(validN), 64'(0));

        // Flush with a full stage and a simultaneous accept/emit request.
        applyStimulus(1'b1, 32'h5000, tagInstr(32'h5000), 5'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5004, tagInstr(32'h5004), 5'd8, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5008, tagInstr(32'h5008), 5'd9, 1'b1, 1'b0, 1'b1);
        checkOutput("flush.pre.occupancy", 64'(occS), 64'(2));
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush.occupancy", 64'(occS), 64'(0));
        checkOutput("flush.out_instr", 64'(instrS), 64'(0));
        checkOutput("flush.out_exc", 64'(excS), 64'(0));
        checkOutput("flush.out_pc", 64'(pcS), 64'(32'h5000));
        checkOutput("flush.noskid.out_pc", 64'(pcN), 64'(32'h5000));

        // Asynchronous reset while the skid stage holds two entries.
        applyStimulus(1'b1, 32'h6000, tagInstr(32'h6000), 5'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h6004, tagInstr(32'h6004), 5'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h6008, tagInstr(32'h6008), 5'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("rstmid.pre.occupancy", 64'(occS), 64'(2));
        #2 reset = 1'b0;
        #1;
        armed = 1'b0;
        resetModel();
        checkOutput("rstmid.out_valid", 64'(validS), 64'(0));
        checkOutput("rstmid.out_pc", 64'(pcS), 64'(32'h3000));
        checkOutput("rstmid.occupancy", 64'(occS), 64'(0));
        checkOutput("rstmid.noskid.out_valid", 64'(validN), 64'(0));
        applyStimulus(1'b1, 32'h6100, tagInstr(32'h6100), 5'd5, 1'b1, 1'b0, 1'b0);
        releaseReset();

        // Back-to-back streaming: 100 entries should drain in 101 cycles.
        base = 32'h0001_0000;
        dutEmits[0] = 0; dutEmits[1] = 0;
        seen[0] = 0; seen[1] = 0;
        for (int i = 0; i <= 100; i++) begin
            applyStimulus(i < 100, base + 32'(4 * i), tagInstr(base + 32'(4 * i)), 5'(i),
                          1'b1, 1'b0, 1'b0);
            if (validS) begin
                checkOutput("stream.skid.order", 64'(pcS), 64'(base + 32'(4 * seen[1])));
                seen[1]++;
            end
            if (validN) begin
                checkOutput("stream.noskid.order", 64'(pcN), 64'(base + 32'(4 * seen[0])));
                seen[0]++;
            end
        end
        checkOutput("stream.skid.emits", 64'(dutEmits[1]), 64'(100));
        checkOutput("stream.noskid.emits", 64'(dutEmits[0]), 64'(100));

        // Random traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom | 32'h1, 5'($urandom),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
                          $urandom_range(0, 99) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
